// File: rtl/nibble_arb.sv
// nibble_arb: two requesters share one 8-bit register split into two 4-bit
// lanes. Each lane arbitrates independently with a 1-bit round-robin pointer.
// Optional lane ownership ("lock") is compiled in when NIBBLE_ARB_LOCK_EN is
// defined; without it the lock inputs are ignored and the lanes never leave IDLE.
module nibble_arb #(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic       i_clk,
   input  logic       i_arst,
   input  logic [1:0] i_req_valid,
   input  logic [1:0] i_req_lane,
   input  logic [3:0] i_req_data0,
   input  logic [3:0] i_req_data1,
   input  logic [1:0] i_req_lock,
   output logic [1:0] o_req_ready,
   output logic [7:0] o_x,
   output logic [1:0] o_lane_locked
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } lane_st_e;

   // Grant vector {req1, req0} for one lane given its state, pointer and the
   // requesters currently targeting it.
   function automatic logic [1:0] lane_grant(input lane_st_e st,
                                             input logic     rr,
                                             input logic [1:0] v);
      logic [1:0] g;
      case (st)
         ST_IDLE: begin
            if (v == 2'b11) begin
               g = rr ? 2'b10 : 2'b01;
            end else begin
               g = v;
            end
         end
         ST_OWN0: g = {1'b0, v[0]};
         ST_OWN1: g = {v[1], 1'b0};
         default: g = 2'b00;
      endcase
      return g;
   endfunction

`ifdef NIBBLE_ARB_LOCK_EN
   // Ownership transitions for one lane. Release happens on the first edge
   // where the owner's lock is low, whether or not it is transferring.
   function automatic lane_st_e lane_next(input lane_st_e   st,
                                          input logic [1:0] gnt,
                                          input logic [1:0] lock);
      lane_st_e n;
      case (st)
         ST_IDLE: begin
            if (gnt[0] && lock[0]) begin
               n = ST_OWN0;
            end else if (gnt[1] && lock[1]) begin
               n = ST_OWN1;
            end else begin
               n = ST_IDLE;
            end
         end
         ST_OWN0: n = lock[0] ? ST_OWN0 : ST_IDLE;
         ST_OWN1: n = lock[1] ? ST_OWN1 : ST_IDLE;
         default: n = ST_IDLE;
      endcase
      return n;
   endfunction
`endif

   lane_st_e   lane0_st_q, lane0_st_d;
   lane_st_e   lane1_st_q, lane1_st_d;
   logic [1:0] rr_q, rr_d;
   logic [7:0] x_q, x_d;

   logic [1:0] lane0_v_s, lane1_v_s;
   logic [1:0] gnt0_s, gnt1_s;

`ifndef NIBBLE_ARB_LOCK_EN
   logic unused_lock_s;
   assign unused_lock_s = ^i_req_lock;
`endif

   // Per-lane request decode and grant selection.
   always_comb begin
      lane0_v_s = {i_req_valid[1] & ~i_req_lane[1], i_req_valid[0] & ~i_req_lane[0]};
      lane1_v_s = {i_req_valid[1] &  i_req_lane[1], i_req_valid[0] &  i_req_lane[0]};
      gnt0_s    = lane_grant(lane0_st_q, rr_q[0], lane0_v_s);
      gnt1_s    = lane_grant(lane1_st_q, rr_q[1], lane1_v_s);
      if (i_arst) begin
         o_req_ready = 2'b00;
      end else begin
         o_req_ready = gnt0_s | gnt1_s;
      end
   end

   // Next-state: lane data, round-robin pointers and lane ownership.
   always_comb begin
      x_d = x_q;
      if (gnt0_s[0]) begin
         x_d[3:0] = i_req_data0;
      end else if (gnt0_s[1]) begin
         x_d[3:0] = i_req_data1;
      end else begin
         x_d[3:0] = x_q[3:0];
      end
      if (gnt1_s[0]) begin
         x_d[7:4] = i_req_data0;
      end else if (gnt1_s[1]) begin
         x_d[7:4] = i_req_data1;
      end else begin
         x_d[7:4] = x_q[7:4];
      end

      // Pointer flips only on genuine contention in an unowned lane.
      rr_d[0] = rr_q[0] ^ ((lane0_st_q == ST_IDLE) && (lane0_v_s == 2'b11));
      rr_d[1] = rr_q[1] ^ ((lane1_st_q == ST_IDLE) && (lane1_v_s == 2'b11));

`ifdef NIBBLE_ARB_LOCK_EN
      lane0_st_d = lane_next(lane0_st_q, gnt0_s, i_req_lock);
      lane1_st_d = lane_next(lane1_st_q, gnt1_s, i_req_lock);
`else
      lane0_st_d = ST_IDLE;
      lane1_st_d = ST_IDLE;
`endif
   end

   // State registers; reset drops ownership and restarts round-robin at requester 0.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         x_q        <= RESET_VAL;
         rr_q       <= 2'b00;
         lane0_st_q <= ST_IDLE;
         lane1_st_q <= ST_IDLE;
      end else begin
         x_q        <= x_d;
         rr_q       <= rr_d;
         lane0_st_q <= lane0_st_d;
         lane1_st_q <= lane1_st_d;
      end
   end

   assign o_x = x_q;

`ifdef NIBBLE_ARB_LOCK_EN
   assign o_lane_locked = {lane1_st_q != ST_IDLE, lane0_st_q != ST_IDLE};
`else
   assign o_lane_locked = 2'b00;
`endif

endmodule

// File: doc/nibble_arb.md
NIBBLE_ARB -- requirements
Module: nibble_arb

Interface
REQ-001 Parameter RESET_VAL, default 8'h00: reset value of the shared register.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_arst  input  1  reset, asynchronous, active-high.
REQ-004 i_req_valid  input  2  bit n: requester n has a pending nibble write.
REQ-005 i_req_lane  input  2  bit n: lane targeted by requester n (0 = bits [3:0], 1 = bits [7:4]).
REQ-006 i_req_data0  input  4  write data, requester 0.
REQ-007 i_req_data1  input  4  write data, requester 1.
REQ-008 i_req_lock  input  2  bit n: requester n asks to keep ownership of its granted lane.
REQ-009 o_req_ready  output  2  bit n: requester n granted this cycle; combinational from current inputs and state.
REQ-010 o_x  output  8  shared register, driven directly from flops.
REQ-011 o_lane_locked  output  2  bit L: lane L is currently owned (lane FSM not IDLE).

Function
REQ-012 Each lane L SHALL have an FSM with states IDLE, OWN0, OWN1, and a 1-bit round-robin pointer rr[L].
REQ-013 Transfer: requester n transfers when i_req_valid[n] && o_req_ready[n]; o_x lane bits SHALL take i_req_dataN at the next rising edge (latency 1); the other lane SHALL be unchanged by that transfer.
REQ-014 In IDLE with one valid requester targeting L, that requester SHALL be granted the same cycle.
REQ-015 In IDLE with both requesters targeting L, requester rr[L] SHALL be granted; the other SHALL see ready 0; rr[L] SHALL flip on that edge.
REQ-016 With no contention, rr[L] SHALL be unchanged.
REQ-017 Requesters targeting different lanes SHALL both be granted in the same cycle, and both nibbles SHALL update on the same edge.
REQ-018 o_req_ready[n] SHALL be 0 whenever i_req_valid[n] is 0.
REQ-019 IDLE -> OWNn when requester n transfers on lane L with i_req_lock[n] = 1.
REQ-020 In OWNn, only requester n SHALL be granted lane L, without arbitration; the other requester's ready SHALL be 0 for lane L.
REQ-021 OWNn -> IDLE on the first edge at which i_req_lock[n] = 0, regardless of valid; a transfer by n in that same cycle SHALL still complete.
REQ-022 While in OWNn, lock SHALL be tracked per lane; requester n retargeting the other lane SHALL arbitrate there normally and SHALL NOT release lane L.
REQ-023 rr[L] SHALL NOT change while lane L is in OWN0 or OWN1.
REQ-024 o_lane_locked[L] SHALL be 1 exactly when lane L is in OWN0 or OWN1.

Reset
REQ-025 On i_arst assertion, regardless of clock, the block SHALL set o_x = RESET_VAL, both lane FSMs = IDLE, and rr = 2'b00 (requester 0 wins first contention).
REQ-026 Reset mid-lock SHALL drop ownership immediately; o_lane_locked = 0 while i_arst is high.
REQ-027 o_req_ready SHALL be 0 while i_arst is high; no transfer completes during reset.

Configuration
REQ-028 Macro NIBBLE_ARB_LOCK_EN defined: lock behaviour per REQ-019..REQ-024 is present.
REQ-029 NIBBLE_ARB_LOCK_EN undefined: i_req_lock SHALL be ignored, the lane FSMs SHALL remain in IDLE, o_lane_locked SHALL be tied 2'b00, and arbitration SHALL be pure round-robin per lane.

Verification
REQ-030 Reset, then req0 lane0 data 4'h0 and req1 lane1 data 4'hF in the same cycle -> both ready = 1, o_x = 8'hF0 one edge later.
REQ-031 Both requesters target lane0 for 4 consecutive cycles (data 4'h1 / 4'h2) -> grants alternate 0,1,0,1; o_x[3:0] sequence 1,2,1,2.
REQ-032 (LOCK_EN) req0 lane1 with lock = 1, data 4'hA; req1 requests lane1 for 3 cycles -> req1 ready = 0 throughout, o_lane_locked = 2'b10; after req0 drops lock, req1 is granted next cycle.
REQ-033 (LOCK_EN) i_arst pulsed while lane0 is in OWN1 -> o_x = RESET_VAL and o_lane_locked = 0 immediately; next contention on lane0 grants requester 0.
REQ-034 Macro undefined, repeat REQ-032 stimulus -> lock ignored, lane1 grants alternate by round-robin.
REQ-035 RESET_VAL = 8'h5A, no requests for 10 cycles -> o_x holds 8'h5A, o_req_ready = 0.
